enemy_sequencer: RTL and testbench
==================================

// Module: enemy_sequencer
// PURPOSE
//  Parametrised per-frame sequencer for N enemies. Each frame, it visits every enemy slot round-robin:
//  optional erase, then decide (enemy controller), then plot (plotter), with full done-handshakes.
//  Sits between the frame timebase, the enemy controllers and the shared VGA plotter.
// PARAMETERS
//  N_ENEMIES      4       enemy slots serviced per frame (1..16)
//  IDX_W          2       width of slot index; must satisfy 2**IDX_W >= N_ENEMIES
//  FRAME_DIV      833334  clock cycles per frame tick (60 Hz at 50 MHz); >= 2
//  DECIDE_TMO     255     max cycles in DECIDE before forced skip; >= 1
// PORTS
//  clock        in   1      system clock
//  reset_n      in   1      synchronous reset, active-low
//  enable       in   1      sequencer run enable; low freezes everything
//  ec_en        out  1      request a move decision from enemy ec_idx
//  ec_done      in   1      decision complete (1-cycle pulse or level)
//  plot_en      out  1      request a draw of enemy plot_idx
//  erase_en     out  1      request an erase of enemy plot_idx (macro only; else tied 0)
//  plot_done    in   1      draw/erase complete
//  slot_idx     out  IDX_W  slot being serviced; shared by ec_idx and plot_idx
//  frame_done   out  1      1-cycle pulse after the last slot's plot completes
//  busy         out  1      high in any state except IDLE
//  tmo_err      out  1      sticky: a DECIDE timed out
//  overrun_err  out  1      sticky: a frame tick arrived while busy
// BEHAVIOUR
//  - Reset: state=IDLE, slot_idx=0, every output=0, frame counter=0, pending tick cleared,
//    sticky flags cleared. Reset mid-sequence aborts at once, with no completion pulse.
//  - Frame counter: counts 0..FRAME_DIV-1 while enable=1; tick is asserted on the wrap cycle.
//  - FSM: IDLE -> [ERASE] -> DECIDE -> PLOT -> (last slot ? DONE : next slot's [ERASE]/DECIDE); DONE -> IDLE.
//  - IDLE: leaves on a tick or a pending tick; slot_idx=0 on entry to the sequence.
//  - ERASE: erase_en=1 until plot_done is sampled high, then go to DECIDE.
//  - DECIDE: ec_en=1, and a cycle counter runs. On ec_done=1, go to PLOT. If DECIDE_TMO cycles
//    elapse without ec_done, set tmo_err and go to PLOT (the enemy is redrawn at its old position).
//  - PLOT: plot_en=1 until plot_done is sampled high. Then slot_idx increments, or goes to DONE
//    when slot_idx==N_ENEMIES-1.
//  - DONE: frame_done=1 for exactly 1 cycle, then IDLE.
//  - Outputs ec_en/plot_en/erase_en/frame_done/busy are Moore outputs, decoded from the registered state.
//  - Done inputs are honoured only in their matching state. A done seen on the first cycle
//    of a state is accepted, so the minimum dwell is 1 cycle. Stray dones are ignored.
//  - A tick while busy sets a one-deep pending flag and sets overrun_err. Further ticks while
//    the flag is set are dropped. The pending flag is consumed on the IDLE exit.
//  - enable=0: state, slot_idx, counters and pending flag hold; all request outputs and
//    frame_done are forced 0. Operation resumes in the same state when enable returns.
//  - slot_idx never exceeds N_ENEMIES-1; index wrap is explicit, not modulo 2**IDX_W.
// CONFIGURATION
//  ENEMY_SEQ_ERASE_EN defined: each slot visits ERASE before DECIDE (old sprite cleared first).
//  Not defined: ERASE state is absent, erase_en is tied 0, and slots go straight to DECIDE.
// STRUCTURE
//  Shared package enemy_seq_pkg holds the state encodings (IDLE, ERASE, DECIDE, PLOT, DONE;
//  3-bit) and the default FRAME_DIV/DECIDE_TMO constants.
//  Sub-module frame_tick_gen (param FRAME_DIV; ports clock, reset_n, enable, tick) is the
//  frame counter.
// TESTING
//  1. N=4, FRAME_DIV=16; ec_done/plot_done echo 2 cycles after their request -> frame_done
//     pulses once per tick; slot_idx visits 0,1,2,3.
//  2. ec_done never asserted, DECIDE_TMO=5 -> DECIDE lasts 5 cycles, tmo_err=1, PLOT still
//     occurs for that slot.
//  3. plot_done held for 20 cycles (FRAME_DIV=16) -> overrun_err=1; exactly one extra
//     sequence starts right after DONE.
//  4. enable dropped for 10 cycles in PLOT -> plot_en=0 during the drop; state and slot_idx
//     unchanged; PLOT resumes afterwards.
//  5. reset_n=0 for 1 cycle at slot 2 DECIDE -> next cycle all outputs are 0, state is IDLE,
//     and the sticky flags are cleared.
//  6. With ENEMY_SEQ_ERASE_EN: order per slot is erase_en, ec_en, plot_en. Without it:
//     erase_en never rises.

Source files
------------

// File: rtl/enemy_seq_pkg.sv
// Shared state encodings and default timing constants for the enemy sequencer.
package enemy_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_DECIDE = 3'd2,
    S_PLOT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int FRAME_DIV_DEF  = 833334;
  localparam int DECIDE_TMO_DEF = 255;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame timebase: counts 0..FRAME_DIV-1 while enabled, tick on the wrap cycle.
module frame_tick_gen
  import enemy_seq_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(FRAME_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) count <= '0;
    else if (enable) count <= (count == LAST) ? '0 : count + 1'b1;
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/enemy_sequencer.sv
// Per-frame round-robin sequencer: [erase] -> decide -> plot for each enemy slot.
// Define ENEMY_SEQ_ERASE_EN to visit ERASE before DECIDE in every slot.
module enemy_sequencer
  import enemy_seq_pkg::*;
#(
  parameter int N_ENEMIES  = 4,
  parameter int IDX_W      = 2,
  parameter int FRAME_DIV  = FRAME_DIV_DEF,
  parameter int DECIDE_TMO = DECIDE_TMO_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  output logic             ec_en,
  input  logic             ec_done,
  output logic             plot_en,
  output logic             erase_en,
  input  logic             plot_done,
  output logic [IDX_W-1:0] slot_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             tmo_err,
  output logic             overrun_err
);

  localparam int TMO_W = $clog2(DECIDE_TMO + 1);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_ENEMIES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(DECIDE_TMO - 1);
`ifdef ENEMY_SEQ_ERASE_EN
  localparam state_t SLOT_ENTRY = S_ERASE;
`else
  localparam state_t SLOT_ENTRY = S_DECIDE;
`endif

  state_t           state, next_state;
  logic             tick, pending;
  logic [TMO_W-1:0] tmo_cnt;
  logic             start, slot_next, tmo_hit;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= S_IDLE;
    else if (enable) state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    slot_next  = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick || pending) begin
          next_state = SLOT_ENTRY;
          start      = 1'b1;
        end
      end
`ifdef ENEMY_SEQ_ERASE_EN
      S_ERASE: if (plot_done) next_state = S_DECIDE;
`endif
      // A late decision on the final timeout cycle still wins over the timeout.
      S_DECIDE: begin
        if (ec_done) next_state = S_PLOT;
        else if (tmo_cnt == TMO_LAST) begin
          next_state = S_PLOT;
          tmo_hit    = 1'b1;
        end
      end
      S_PLOT: begin
        if (plot_done) begin
          if (slot_idx == LAST_SLOT) next_state = S_DONE;
          else begin
            next_state = SLOT_ENTRY;
            slot_next  = 1'b1;
          end
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    ec_en      = enable && (state == S_DECIDE);
    plot_en    = enable && (state == S_PLOT);
`ifdef ENEMY_SEQ_ERASE_EN
    erase_en   = enable && (state == S_ERASE);
`else
    erase_en   = 1'b0;
`endif
    frame_done = enable && (state == S_DONE);
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_idx    <= '0;
      tmo_cnt     <= '0;
      pending     <= 1'b0;
      tmo_err     <= 1'b0;
      overrun_err <= 1'b0;
    end else if (enable) begin
      if (start) slot_idx <= '0;
      else if (slot_next) slot_idx <= slot_idx + 1'b1;

      if ((state == S_DECIDE) && (next_state == S_DECIDE)) tmo_cnt <= tmo_cnt + 1'b1;
      else tmo_cnt <= '0;

      if (tmo_hit) tmo_err <= 1'b1;

      // One-deep tick memory; extra ticks while it is set are simply lost.
      if (start) pending <= 1'b0;
      else if (tick && (state != S_IDLE)) begin
        pending     <= 1'b1;
        overrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_enemy_sequencer.sv
// Directed bench for enemy_sequencer (N=4, FRAME_DIV=16, DECIDE_TMO=5) with auto-echo responders.
module tb_enemy_sequencer;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       ec_done = 1'b0;
  logic       plot_done = 1'b0;
  logic       ec_en, plot_en, erase_en, frame_done, busy, tmo_err, overrun_err;
  logic [1:0] slot_idx;

`ifdef ENEMY_SEQ_ERASE_EN
  localparam logic [1:0] FIRST_REQ = 2'b10;  // {erase_en, ec_en} on slot entry
  localparam int         PER_SLOT  = 3;
`else
  localparam logic [1:0] FIRST_REQ = 2'b01;
  localparam int         PER_SLOT  = 2;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Responder knobs and monitor state
  int   ec_lat = 2, pl_lat = 2;
  bit   ec_auto = 1'b1, stray = 1'b0;
  int   ec_age = 0, pl_age = 0, er_age = 0;
  int   evt_q[$];
  int   slot_q[$];
  int   frame_cnt = 0;
  bit   erase_seen = 1'b0;
  logic prev_ec = 1'b0, prev_pl = 1'b0, prev_er = 1'b0;

  enemy_sequencer #(
    .N_ENEMIES (N),
    .IDX_W     (2),
    .FRAME_DIV (16),
    .DECIDE_TMO(5)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .ec_en      (ec_en),
    .ec_done    (ec_done),
    .plot_en    (plot_en),
    .erase_en   (erase_en),
    .plot_done  (plot_done),
    .slot_idx   (slot_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .tmo_err    (tmo_err),
    .overrun_err(overrun_err)
  );

  always #5 clock = ~clock;

  // Event log (1=erase, 2=decide, 3=plot rising) and done echoes, on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (erase_en === 1'b1 && prev_er !== 1'b1) begin
        evt_q.push_back(1); slot_q.push_back(int'(slot_idx)); erase_seen = 1'b1;
      end
      if (ec_en === 1'b1 && prev_ec !== 1'b1) begin
        evt_q.push_back(2); slot_q.push_back(int'(slot_idx));
      end
      if (plot_en === 1'b1 && prev_pl !== 1'b1) begin
        evt_q.push_back(3); slot_q.push_back(int'(slot_idx));
      end
      if (frame_done === 1'b1) frame_cnt++;
      prev_ec = ec_en; prev_pl = plot_en; prev_er = erase_en;
      ec_age = (ec_en === 1'b1) ? ec_age + 1 : 0;
      pl_age = (plot_en === 1'b1) ? pl_age + 1 : 0;
      er_age = (erase_en === 1'b1) ? er_age + 1 : 0;
      ec_done   = stray || (ec_auto && ec_age >= ec_lat);
      plot_done = stray || (pl_age >= pl_lat && pl_lat > 0 && plot_en === 1'b1) || (er_age >= 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    enable = 1'b1; ec_auto = 1'b1; ec_lat = 2; pl_lat = 2; stray = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    evt_q.delete(); slot_q.delete(); frame_cnt = 0;
  endtask

  task automatic test_reset();
    enable = 1'b1; ec_auto = 1'b1; ec_lat = 2; pl_lat = 2; stray = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    total_cnt++;
    if ({ec_en, plot_en, erase_en, frame_done, busy, tmo_err, overrun_err} !== 7'b0)
      $display("FAIL reset_outputs: got %b, want 0000000",
               {ec_en, plot_en, erase_en, frame_done, busy, tmo_err, overrun_err});
    else pass_cnt++;
    total_cnt++;
    if (slot_idx !== 2'd0) $display("FAIL reset_slot: got %0d, want 0", slot_idx);
    else pass_cnt++;
    reset_n = 1'b1;
    evt_q.delete(); slot_q.delete(); frame_cnt = 0;
    stray = 1'b1;  // dones while idle must be ignored
    repeat (15) step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_before_tick: busy got %b, want 0", busy);
    else pass_cnt++;
    step();
    stray = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL first_tick_busy: got %b, want 1", busy);
    else pass_cnt++;
    total_cnt++;
    if ({erase_en, ec_en} !== FIRST_REQ)
      $display("FAIL first_request: got %b, want %b", {erase_en, ec_en}, FIRST_REQ);
    else pass_cnt++;
  endtask

  task automatic test_frame_sequence();
    int k;
    apply_reset();
    ec_lat = 1; pl_lat = 1;
    repeat (62) step();
    total_cnt++;
    if (frame_cnt !== 3) $display("FAIL frame_pulses: got %0d, want 3", frame_cnt);
    else pass_cnt++;
    k = 0;
    foreach (evt_q[i]) begin
      if (evt_q[i] == 2) begin
        total_cnt++;
        if (slot_q[i] !== k % N) $display("FAIL slot_order[%0d]: got %0d, want %0d", k, slot_q[i], k % N);
        else pass_cnt++;
        k++;
      end
    end
    total_cnt++;
    if (k !== 3 * N) $display("FAIL decide_count: got %0d, want %0d", k, 3 * N);
    else pass_cnt++;
    total_cnt++;
    if ({overrun_err, tmo_err, busy} !== 3'b000)
      $display("FAIL frame_flags: got %b, want 000", {overrun_err, tmo_err, busy});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    ec_auto = 1'b0; pl_lat = 1;
    n = 0;
    while (ec_en !== 1'b1 && n < 40) begin step(); n++; end
    total_cnt++;
    if (ec_en !== 1'b1) $display("FAIL decide_reached: ec_en got %b, want 1", ec_en);
    else pass_cnt++;
    total_cnt++;
    if (tmo_err !== 1'b0) $display("FAIL tmo_err_early: got %b, want 0", tmo_err);
    else pass_cnt++;
    n = 0;
    while (ec_en === 1'b1 && n < 20) begin step(); n++; end
    total_cnt++;
    if (n !== 5) $display("FAIL decide_dwell: got %0d cycles, want 5", n);
    else pass_cnt++;
    total_cnt++;
    if ({plot_en, slot_idx} !== 3'b100)
      $display("FAIL plot_after_tmo: got plot_en=%b slot=%0d, want plot_en=1 slot=0", plot_en, slot_idx);
    else pass_cnt++;
    total_cnt++;
    if (tmo_err !== 1'b1) $display("FAIL tmo_err_set: got %b, want 1", tmo_err);
    else pass_cnt++;
    ec_auto = 1'b1;
  endtask

  task automatic test_overrun();
    int n;
    apply_reset();
    pl_lat = 20;
    n = 0;
    while (plot_en !== 1'b1 && n < 40) begin step(); n++; end
    total_cnt++;
    if (plot_en !== 1'b1) $display("FAIL long_plot_reached: plot_en got %b, want 1", plot_en);
    else pass_cnt++;
    total_cnt++;
    if (overrun_err !== 1'b0) $display("FAIL overrun_early: got %b, want 0", overrun_err);
    else pass_cnt++;
    n = 0;
    while (plot_en === 1'b1 && n < 30) begin step(); n++; end
    total_cnt++;
    if (n !== 20) $display("FAIL plot_dwell: got %0d cycles, want 20", n);
    else pass_cnt++;
    ec_lat = 1; pl_lat = 1;
    total_cnt++;
    if (overrun_err !== 1'b1) $display("FAIL overrun_set: got %b, want 1", overrun_err);
    else pass_cnt++;
    n = 0;
    while (frame_done !== 1'b1 && n < 60) begin step(); n++; end
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL overrun_frame_done: got %b, want 1", frame_done);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_done: busy got %b, want 0", busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy, slot_idx, erase_en, ec_en} !== {1'b1, 2'd0, FIRST_REQ})
      $display("FAIL pending_restart: got busy=%b slot=%0d req=%b, want busy=1 slot=0 req=%b",
               busy, slot_idx, {erase_en, ec_en}, FIRST_REQ);
    else pass_cnt++;
  endtask

  task automatic test_enable_hold();
    int n, req_bad, hold_bad;
    logic [1:0] s;
    apply_reset();
    n = 0;
    while (plot_en !== 1'b1 && n < 40) begin step(); n++; end
    total_cnt++;
    if (plot_en !== 1'b1) $display("FAIL hold_plot_reached: plot_en got %b, want 1", plot_en);
    else pass_cnt++;
    s = slot_idx;
    enable = 1'b0;
    #1;
    req_bad = 0; hold_bad = 0;
    repeat (10) begin
      if ({plot_en, ec_en, erase_en, frame_done} !== 4'b0) req_bad++;
      if (busy !== 1'b1 || slot_idx !== s) hold_bad++;
      step();
    end
    total_cnt++;
    if (req_bad !== 0) $display("FAIL disabled_requests: got %0d active cycles, want 0", req_bad);
    else pass_cnt++;
    total_cnt++;
    if (hold_bad !== 0) $display("FAIL disabled_hold: got %0d changed cycles, want 0", hold_bad);
    else pass_cnt++;
    enable = 1'b1;
    #1;
    total_cnt++;
    if ({plot_en, slot_idx} !== {1'b1, s})
      $display("FAIL plot_resume: got plot_en=%b slot=%0d, want plot_en=1 slot=%0d", plot_en, slot_idx, s);
    else pass_cnt++;
    n = 0;
    while (plot_en === 1'b1 && n < 10) begin step(); n++; end
    total_cnt++;
    if ({erase_en, ec_en, slot_idx} !== {FIRST_REQ, s + 2'd1})
      $display("FAIL after_resume: got req=%b slot=%0d, want req=%b slot=%0d",
               {erase_en, ec_en}, slot_idx, FIRST_REQ, s + 2'd1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n, fc;
    apply_reset();
    ec_auto = 1'b0; pl_lat = 1;
    n = 0;
    while (plot_en !== 1'b1 && n < 40) begin step(); n++; end
    ec_auto = 1'b1; ec_lat = 1;
    total_cnt++;
    if (tmo_err !== 1'b1) $display("FAIL mid_tmo_set: got %b, want 1", tmo_err);
    else pass_cnt++;
    n = 0;
    while (!(ec_en === 1'b1 && slot_idx === 2'd2) && n < 40) begin step(); n++; end
    total_cnt++;
    if ({ec_en, slot_idx} !== 3'b110)
      $display("FAIL slot2_decide: got ec_en=%b slot=%0d, want ec_en=1 slot=2", ec_en, slot_idx);
    else pass_cnt++;
    reset_n = 1'b0;
    step();
    total_cnt++;
    if ({ec_en, plot_en, erase_en, frame_done, busy, tmo_err, overrun_err, slot_idx} !== 9'b0)
      $display("FAIL mid_reset_clear: got %b, want 000000000",
               {ec_en, plot_en, erase_en, frame_done, busy, tmo_err, overrun_err, slot_idx});
    else pass_cnt++;
    reset_n = 1'b1;
    fc = frame_cnt;
    repeat (8) step();
    total_cnt++;
    if ({frame_cnt == fc, busy} !== 2'b10)
      $display("FAIL mid_reset_abort: got frames=%0d busy=%b, want frames=%0d busy=0", frame_cnt, busy, fc);
    else pass_cnt++;
  endtask

  task automatic test_order();
    int n, exp_code, exp_slot;
    apply_reset();
    ec_lat = 1; pl_lat = 1;
    n = 0;
    while (frame_done !== 1'b1 && n < 60) begin step(); n++; end
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL order_frame_done: got %b, want 1", frame_done);
    else pass_cnt++;
    total_cnt++;
    if (evt_q.size() !== N * PER_SLOT) $display("FAIL order_count: got %0d events, want %0d", evt_q.size(), N * PER_SLOT);
    else pass_cnt++;
    for (int i = 0; i < evt_q.size() && i < N * PER_SLOT; i++) begin
      exp_code = (i % PER_SLOT) + 4 - PER_SLOT;
      exp_slot = i / PER_SLOT;
      total_cnt++;
      if (evt_q[i] !== exp_code || slot_q[i] !== exp_slot)
        $display("FAIL order[%0d]: got event %0d slot %0d, want event %0d slot %0d",
                 i, evt_q[i], slot_q[i], exp_code, exp_slot);
      else pass_cnt++;
    end
`ifndef ENEMY_SEQ_ERASE_EN
    total_cnt++;
    if (erase_seen !== 1'b0) $display("FAIL erase_never: erase_en rose, want never");
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_frame_sequence();
    test_timeout();
    test_overrun();
    test_enable_hold();
    test_reset_mid();
    test_order();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
